// File: rtl/uart_cmd_switch_bank.sv
// Decodes "<PREFIX><ch><0|1>[TERM]" ASCII frames from a UART byte stream into
// NCH latched enables, with per-channel edge pulses and frame accept/reject strobes.
module uart_cmd_switch_bank #(
    parameter int              NCH         = 4,
    parameter logic [7:0]      PREFIX      = 8'h4D,
    parameter bit              USE_TERM    = 1'b1,
    parameter logic [7:0]      TERM        = 8'h0A,
    parameter int              TIMEOUT_CYC = 500000,
    parameter logic [NCH-1:0]  INIT_STATE  = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [7:0]     rx_data,
    input  logic           rx_valid,
    output logic [NCH-1:0] ch_state,
    output logic [NCH-1:0] ch_rise,
    output logic [NCH-1:0] ch_fall,
    output logic           cmd_ok,
    output logic           cmd_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GOT_PFX = 2'd1,
        GOT_CH  = 2'd2,
        GOT_VAL = 2'd3
    } state_e;

    // Counter only ever needs to reach TIMEOUT_CYC-1.
    localparam int             CW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [7:0]     CH_LIMIT = 8'h30 + 8'(NCH);

    state_e         state_q, state_d;
    logic [3:0]     ch_q, ch_d;
    logic           val_q, val_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [NCH-1:0] ch_state_q, ch_state_d;
    logic [NCH-1:0] rise_q, rise_d;
    logic [NCH-1:0] fall_q, fall_d;
    logic           ok_q, ok_d;
    logic           err_q, err_d;

    logic           commit;
    logic           commit_val;
    logic           frame_err;
    logic           timeout_hit;
    logic           is_chan;
    logic           is_bit;
    logic [3:0]     ch_idx;

    // Range is checked on the full byte; the 4-bit index is only used once in range.
    assign is_chan     = (rx_data >= 8'h30) && (rx_data < CH_LIMIT);
    assign is_bit      = (rx_data == 8'h30) || (rx_data == 8'h31);
    assign ch_idx      = 4'(rx_data - 8'h30);
    assign timeout_hit = (TIMEOUT_CYC > 0) && (state_q != IDLE) && !rx_valid
                         && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            val_q      <= 1'b0;
            cnt_q      <= '0;
            ch_state_q <= INIT_STATE;
            rise_q     <= '0;
            fall_q     <= '0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            val_q      <= val_d;
            cnt_q      <= cnt_d;
            ch_state_q <= ch_state_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        val_d      = val_q;
        commit     = 1'b0;
        commit_val = val_q;
        frame_err  = 1'b0;

        if (TIMEOUT_CYC == 0 || rx_valid || state_q == IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    if (rx_data == PREFIX) begin
                        state_d = GOT_PFX;
                    end
                end
                GOT_PFX: begin
                    if (is_chan) begin
                        ch_d    = ch_idx;
                        state_d = GOT_CH;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                GOT_CH: begin
                    if (is_bit) begin
                        val_d = rx_data[0];
                        if (USE_TERM) begin
                            state_d = GOT_VAL;
                        end else begin
                            commit     = 1'b1;
                            commit_val = rx_data[0];
                            state_d    = IDLE;
                        end
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                GOT_VAL: begin
                    if (rx_data == TERM) begin
                        commit  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (timeout_hit) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        // A stray PREFIX inside a frame is taken as the start of a new one.
        if (frame_err) begin
            state_d = (rx_data == PREFIX) ? GOT_PFX : IDLE;
        end
    end

    always_comb begin
        ok_d  = commit;
        err_d = frame_err | timeout_hit;
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic hit;
        assign hit            = commit && (ch_q == 4'(gi));
        assign ch_state_d[gi] = hit ? commit_val : ch_state_q[gi];
        assign rise_d[gi]     = hit && commit_val && !ch_state_q[gi];
        assign fall_d[gi]     = hit && !commit_val && ch_state_q[gi];
    end

    assign ch_state = ch_state_q;
    assign ch_rise  = rise_q;
    assign ch_fall  = fall_q;
    assign cmd_ok   = ok_q;
    assign cmd_err  = err_q;

endmodule

// File: tb/tb_uart_cmd_switch_bank.sv
// Bench for uart_cmd_switch_bank: a terminated-frame instance and a no-terminator
// instance, each checked every cycle against a frame-buffer reference model.
module tb_uart_cmd_switch_bank;

    localparam int         NCH  = 4;
    localparam int         TMO  = 100;
    localparam logic [7:0] C_M  = 8'h4D;
    localparam logic [7:0] C_0  = 8'h30;
    localparam logic [7:0] C_NL = 8'h0A;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [7:0]     rx_data_t = 8'h00, rx_data_r = 8'h00;
    logic           rx_valid_t = 1'b0, rx_valid_r = 1'b0;
    logic [NCH-1:0] st_t, ri_t, fa_t, st_r, ri_r, fa_r;
    logic           ok_t, err_t, ok_r, err_r;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_cmd_switch_bank #(
        .NCH(NCH), .PREFIX(C_M), .USE_TERM(1'b1), .TERM(C_NL),
        .TIMEOUT_CYC(TMO), .INIT_STATE('0)
    ) u_term (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data_t), .rx_valid(rx_valid_t),
        .ch_state(st_t), .ch_rise(ri_t), .ch_fall(fa_t), .cmd_ok(ok_t), .cmd_err(err_t)
    );

    uart_cmd_switch_bank #(
        .NCH(NCH), .PREFIX(C_M), .USE_TERM(1'b0), .TERM(C_NL),
        .TIMEOUT_CYC(TMO), .INIT_STATE('0)
    ) u_raw (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data_r), .rx_valid(rx_valid_r),
        .ch_state(st_r), .ch_rise(ri_r), .ch_fall(fa_r), .cmd_ok(ok_r), .cmd_err(err_r)
    );

    // Reference: buffer of accepted frame bytes plus idle-gap count since last byte.
    typedef struct {
        int             len;
        int             gap;
        int             ch;
        bit             vb;
        logic [NCH-1:0] st;
        logic [NCH-1:0] rise;
        logic [NCH-1:0] fall;
        bit             ok;
        bit             err;
    } mdl_t;

    function automatic mdl_t mdl_zero();
        mdl_t z;
        z.len = 0; z.gap = 0; z.ch = 0; z.vb = 1'b0;
        z.st = '0; z.rise = '0; z.fall = '0; z.ok = 1'b0; z.err = 1'b0;
        return z;
    endfunction

    function automatic mdl_t step(mdl_t m, bit v, logic [7:0] b, bit use_term);
        mdl_t n;
        int   frame_len;
        bit   good;
        bit   old;
        n = m;
        n.rise = '0; n.fall = '0; n.ok = 1'b0; n.err = 1'b0;
        frame_len = use_term ? 4 : 3;
        good = 1'b0;
        if (v) begin
            n.gap = 0;
            if (m.len == 0) begin
                if (b == C_M) n.len = 1;
            end else begin
                case (m.len)
                    1:       good = (b >= C_0) && (int'(b) < int'(C_0) + NCH);
                    2:       good = (b == 8'h30) || (b == 8'h31);
                    default: good = (b == C_NL);
                endcase
                if (!good) begin
                    n.err = 1'b1;
                    n.len = (b == C_M) ? 1 : 0;
                end else begin
                    if (m.len == 1) n.ch = int'(b) - int'(C_0);
                    if (m.len == 2) n.vb = b[0];
                    n.len = m.len + 1;
                    if (n.len == frame_len) begin
                        old = m.st[n.ch];
                        n.st[n.ch]   = n.vb;
                        n.rise[n.ch] = n.vb && !old;
                        n.fall[n.ch] = !n.vb && old;
                        n.ok  = 1'b1;
                        n.len = 0;
                    end
                end
            end
        end else if (m.len != 0) begin
            n.gap = m.gap + 1;
            if (n.gap == TMO) begin
                n.err = 1'b1;
                n.len = 0;
                n.gap = 0;
            end
        end
        return n;
    endfunction

    mdl_t m_t, m_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t <= mdl_zero();
            m_r <= mdl_zero();
        end else begin
            m_t <= step(m_t, rx_valid_t, rx_data_t, 1'b1);
            m_r <= step(m_r, rx_valid_r, rx_data_r, 1'b0);
        end
    end

    // Hand-computed expectations posted by the stimulus, checked at the next falling edge.
    string          lit_name = "";
    int             lit_dut = 0;
    logic [NCH-1:0] lit_st = '0, lit_ri = '0, lit_fa = '0;
    bit             lit_ok = 1'b0, lit_err = 1'b0;
    int             lit_seq = 0;
    int             lit_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("t_state", 32'(st_t), 32'(m_t.st));
        chk("t_rise",  32'(ri_t), 32'(m_t.rise));
        chk("t_fall",  32'(fa_t), 32'(m_t.fall));
        chk("t_ok",    32'(ok_t), 32'(m_t.ok));
        chk("t_err",   32'(err_t), 32'(m_t.err));
        chk("r_state", 32'(st_r), 32'(m_r.st));
        chk("r_rise",  32'(ri_r), 32'(m_r.rise));
        chk("r_fall",  32'(fa_r), 32'(m_r.fall));
        chk("r_ok",    32'(ok_r), 32'(m_r.ok));
        chk("r_err",   32'(err_r), 32'(m_r.err));
        if (lit_seq != lit_done) begin
            if (lit_dut == 0) begin
                chk({lit_name, "_state"}, 32'(st_t), 32'(lit_st));
                chk({lit_name, "_rise"},  32'(ri_t), 32'(lit_ri));
                chk({lit_name, "_fall"},  32'(fa_t), 32'(lit_fa));
                chk({lit_name, "_ok"},    32'(ok_t), 32'(lit_ok));
                chk({lit_name, "_err"},   32'(err_t), 32'(lit_err));
            end else begin
                chk({lit_name, "_state"}, 32'(st_r), 32'(lit_st));
                chk({lit_name, "_rise"},  32'(ri_r), 32'(lit_ri));
                chk({lit_name, "_fall"},  32'(fa_r), 32'(lit_fa));
                chk({lit_name, "_ok"},    32'(ok_r), 32'(lit_ok));
                chk({lit_name, "_err"},   32'(err_r), 32'(lit_err));
            end
            $display("check %s (dut %0d) at %0t", lit_name, lit_dut, $time);
            lit_done <= lit_seq;
        end
    end

    task automatic expect_lit(input string name, input int d, input logic [NCH-1:0] st,
                              input logic [NCH-1:0] ri, input logic [NCH-1:0] fa,
                              input bit ok, input bit err);
        lit_name = name; lit_dut = d;
        lit_st = st; lit_ri = ri; lit_fa = fa; lit_ok = ok; lit_err = err;
        lit_seq++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_t(input logic [7:0] b);
        rx_data_t  = b;
        rx_valid_t = 1'b1;
        @(posedge clk);
        #2;
        rx_valid_t = 1'b0;
        $display("byte t 0x%02h at %0t", b, $time);
    endtask

    task automatic send_r(input logic [7:0] b);
        rx_data_r  = b;
        rx_valid_r = 1'b1;
        @(posedge clk);
        #2;
        rx_valid_r = 1'b0;
        $display("byte r 0x%02h at %0t", b, $time);
    endtask

    task automatic str_t(input string s);
        for (int i = 0; i < s.len(); i++) send_t(s[i]);
    endtask

    task automatic str_r(input string s);
        for (int i = 0; i < s.len(); i++) send_r(s[i]);
    endtask

    function automatic logic [7:0] rbyte();
        logic [7:0] b;
        case ($urandom_range(0, 9))
            0, 1:    b = C_M;
            2, 3:    b = 8'(C_0 + 8'($urandom_range(0, 5)));
            4:       b = 8'h31;
            5, 6:    b = C_NL;
            7:       b = 8'h78;
            default: b = 8'($urandom_range(0, 255));
        endcase
        return b;
    endfunction

    initial begin
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        expect_lit("reset_t", 0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        idle(1);
        expect_lit("reset_r", 1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        idle(1);

        str_t("M21\n");
        expect_lit("m21_commit", 0, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0);
        idle(1);
        expect_lit("m21_after", 0, 4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0);
        idle(1);
        str_t("M21\n");
        expect_lit("m21_same", 0, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0);
        str_t("M20\n");
        expect_lit("m20_fall", 0, 4'b0000, 4'b0000, 4'b0100, 1'b1, 1'b0);
        idle(2);

        str_t("M7");
        expect_lit("bad_chan", 0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        str_t("1\n");
        idle(1);
        expect_lit("bad_chan_tail", 0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        str_t("M2x");
        expect_lit("bad_val", 0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        str_t("\n");
        str_t("M21X");
        expect_lit("bad_term", 0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        idle(2);
        str_t("M2M");
        expect_lit("resync_err", 0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        str_t("31\n");
        expect_lit("resync_ok", 0, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b0);
        idle(2);

        str_t("M2");
        idle(TMO - 1);
        expect_lit("tmo_before", 0, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        idle(1);
        expect_lit("tmo_fire", 0, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b1);
        str_t("1\n");
        idle(1);
        expect_lit("tmo_tail", 0, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        idle(1);
        str_t("M2");
        idle(TMO - 2);
        str_t("1\n");
        expect_lit("tmo_edge_ok", 0, 4'b1100, 4'b0100, 4'b0000, 1'b1, 1'b0);
        idle(2);

        str_r("M11");
        expect_lit("raw_first", 1, 4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b0);
        str_r("M01");
        expect_lit("raw_second", 1, 4'b0011, 4'b0001, 4'b0000, 1'b1, 1'b0);
        idle(2);

        str_t("M3");
        rst_n = 1'b0;
        idle(1);
        expect_lit("rst_mid", 0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        idle(1);
        rst_n = 1'b1;
        str_t("1\n");
        idle(1);
        expect_lit("rst_tail", 0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
        idle(1);
        str_t("M31\n");
        expect_lit("rst_after", 0, 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b0);
        idle(2);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 79) == 0) begin
                rx_valid_t = 1'b0;
                rx_valid_r = 1'b0;
                idle($urandom_range(TMO - 3, TMO + 3));
            end else begin
                rx_valid_t = ($urandom_range(0, 2) != 0);
                rx_data_t  = rbyte();
                rx_valid_r = ($urandom_range(0, 2) != 0);
                rx_data_r  = rbyte();
                idle(1);
            end
        end
        rx_valid_t = 1'b0;
        rx_valid_r = 1'b0;
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_switch_bank.md
Name: uart_cmd_switch_bank

Overview:
- Multi-channel successor to the single-switch UART command decoder.
- Parses ASCII command frames from the UART receiver byte stream. Frame format is PREFIX, channel digit, value digit and an optional terminator, e.g. "M21\n" sets channel 2 on.
- Drives NCH latched enable levels, with one-cycle rise/fall pulses per channel and frame accept/error strobes.
- Sits between the UART RX byte output and the power/feature enables.

Parameters:
- NCH, 4: channel count, 1..10; channel digits are '0'..('0'+NCH-1).
- PREFIX, 8'h4D ('M'): frame start byte.
- USE_TERM, 1: 1 = frame must end with TERM; 0 = frame completes on the value byte.
- TERM, 8'h0A ('\n'): terminator byte.
- TIMEOUT_CYC, 500000: max clk cycles between bytes inside a frame; 0 disables the timeout.
- INIT_STATE, {NCH{1'b0}}: reset value of ch_state.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- rx_data  in  8  received byte; valid only when rx_valid=1
- rx_valid  in  1  one-cycle strobe per received byte; may repeat on consecutive cycles
- ch_state  out  NCH  latched channel enable levels
- ch_rise  out  NCH  one-cycle pulse when ch_state[i] goes 0->1
- ch_fall  out  NCH  one-cycle pulse when ch_state[i] goes 1->0
- cmd_ok  out  1  one-cycle pulse per accepted frame
- cmd_err  out  1  one-cycle pulse per rejected or timed-out frame

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset:
  - ch_state = INIT_STATE
  - ch_rise, ch_fall, cmd_ok, cmd_err = 0
  - FSM = IDLE, timeout counter = 0, held channel/value registers = 0
- All outputs are registered.
- FSM states: IDLE, GOT_PFX, GOT_CH, GOT_VAL (GOT_VAL is used only when USE_TERM=1).
- All transitions below happen only on cycles with rx_valid=1:
  - IDLE: byte==PREFIX -> GOT_PFX. Any other byte is ignored: stay in IDLE, no cmd_err.
  - GOT_PFX: byte in '0'..'0'+NCH-1 -> store channel index (byte-8'h30), go to GOT_CH. Otherwise error.
  - GOT_CH: byte '0' or '1' -> store value.
    - USE_TERM=1: go to GOT_VAL.
    - USE_TERM=0: commit, go to IDLE.
    - Any other byte: error.
  - GOT_VAL: byte==TERM -> commit, go to IDLE. Otherwise error.
- Error: cmd_err=1 for one cycle. Next state is GOT_PFX if the offending byte equals PREFIX (resync), else IDLE. Error never modifies ch_state.
- Commit, registered on the cycle after the completing rx_valid:
  - ch_state[ch] <= value; cmd_ok=1.
  - ch_rise[ch]=1 only if old=0 and new=1; ch_fall[ch]=1 only if old=1 and new=0.
  - Pulses coincide with the ch_state change.
  - Same-value write gives cmd_ok with no edge pulse.
  - Other channels are untouched.
- Latency: completing byte strobe at cycle N -> ch_state, edge pulses and cmd_ok visible at cycle N+1.
- Timeout, only when TIMEOUT_CYC>0:
  - Counter clears on every rx_valid and while in IDLE.
  - Counter increments each cycle in any other state.
  - When the counter reaches TIMEOUT_CYC-1 with no rx_valid that cycle: FSM -> IDLE, cmd_err=1 for one cycle, counter clears.
  - If rx_valid coincides with that cycle, the byte is processed normally and no timeout fires.
- Back-to-back frames: the prefix of the next frame may arrive the cycle after the completing byte. It is accepted, and the next commit can occur two rx_valid cycles later with no lost pulses.
- Channel index arithmetic: 4-bit subtract from the byte; range check is done before indexing. No out-of-range write is possible.
- Reset mid-frame: partial frame is discarded, and no pulses are produced for it.

Test Plan:
- Reset, then bytes "M21\n" (NCH=4, USE_TERM=1) -> ch_state=4'b0100, ch_rise=4'b0100 and cmd_ok for exactly 1 cycle, one cycle after the '\n' strobe.
- "M21\n" then "M21\n" then "M20\n" -> second frame: cmd_ok only, no ch_rise. Third frame: ch_fall[2] pulse, ch_state=0.
- Error frames, ch_state must be unchanged in each case:
  - "M71\n" -> cmd_err.
  - "M2x\n" -> cmd_err.
  - "M21X" -> cmd_err.
  - "M2M31\n" -> cmd_err at the second 'M', then frame "M31\n" accepted: ch_state[3]=1.
- TIMEOUT_CYC=100: send "M2" then idle 100 cycles -> cmd_err pulse at cycle 100 after 'M2' strobe. Then "1\n" is ignored and no state changes. A separate run with the third byte arriving at exactly cycle 99 -> frame proceeds.
- USE_TERM=0: back-to-back strobes on consecutive cycles "M11M01" -> ch_state=4'b0011, two cmd_ok pulses, ch_rise[1] then ch_rise[0].
- Assert rst_n low in the middle of "M3" -> outputs = INIT_STATE/0. Subsequent "1\n" is ignored, and "M31\n" then works normally.
